template_match_ctrl: RTL and testbench
======================================

TEMPLATE_MATCH_CTRL -- requirements
Module: template_match_ctrl

Interface
REQ-001 SHALL have parameter N_SAMPLES, default 1000: audio samples per utterance and per template.
REQ-002 SHALL have parameter N_TEMPLATES, default 4: stored word templates, indices 0..N_TEMPLATES-1.
REQ-003 SHALL have parameter THRESHOLD, default 20'd200000: acceptance limit on the best score.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic is on posedge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: request a match pass; sampled only in IDLE.
REQ-007 SHALL have port audio_addr, output, 11 bits: read address into the received-audio buffer.
REQ-008 SHALL have port audio_data, input, 10 bits: audio sample, valid 1 cycle after its address.
REQ-009 SHALL have port tmpl_addr, output, 13 bits: read address {template index, sample index} into the template bank.
REQ-010 SHALL have port tmpl_data, input, 10 bits: template sample, valid 1 cycle after its address.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 SHALL have port done, output, 1 bit: single-cycle pulse when results are final.
REQ-013 SHALL have port best_idx, output, 3 bits: index of the lowest-score template.
REQ-014 SHALL have port best_score, output, 20 bits: sum of absolute differences (SAD) for best_idx.
REQ-015 SHALL have port match_valid, output, 1 bit: best_score < THRESHOLD; valid from done onward.

Function
REQ-016 SHALL implement states IDLE, ACCUM, FLUSH, CMP and DONE.
REQ-017 Transitions SHALL be: IDLE->ACCUM on start; ACCUM->FLUSH after address N_SAMPLES-1 is issued; FLUSH->CMP; CMP->ACCUM if more templates remain, else CMP->DONE; DONE->IDLE.
REQ-018 In ACCUM, each cycle SHALL issue sample index s on both audio_addr and tmpl_addr (template t), with s running 0..N_SAMPLES-1.
REQ-019 SHALL add |audio_data - tmpl_data| to the running sum one cycle after the address is issued; FLUSH accumulates the final sample.
REQ-020 The running sum SHALL saturate at 20'hFFFFF and never wrap.
REQ-021 In CMP, the running sum SHALL replace best_score/best_idx if t==0 or sum < best_score; ties SHALL keep the lower index.
REQ-022 In CMP, the running sum SHALL clear to 0 and t SHALL increment.
REQ-023 done SHALL assert exactly N_TEMPLATES*(N_SAMPLES+2)+1 cycles after the cycle in which start was accepted; this timing holds without EARLY_ABORT_EN.
REQ-024 start SHALL be ignored while busy.
REQ-025 best_idx, best_score and match_valid SHALL hold their values from DONE until the next start is accepted.
REQ-026 On acceptance of start, best_score SHALL be cleared to 20'hFFFFF and best_idx to 0.
REQ-027 Address outputs SHALL be 0 outside ACCUM.

Reset
REQ-028 Reset SHALL force IDLE and set busy=0, done=0, best_idx=0, best_score=0, match_valid=0, addresses=0, sum=0 and t=0.
REQ-029 Reset mid-pass SHALL abandon the pass without a done pulse.
REQ-030 Reset SHALL take priority over start in the same cycle.

Configuration
REQ-031 Macro TEMPLATE_MATCH_EARLY_ABORT_EN SHALL, when defined, move ACCUM directly to CMP once t>0 and sum >= best_score.
REQ-032 An aborted template SHALL never win, and the final best_idx/best_score SHALL be identical to the non-abort build.
REQ-033 When TEMPLATE_MATCH_EARLY_ABORT_EN is undefined, no abort logic SHALL exist and the REQ-023 timing SHALL hold.

Structure
REQ-034 Package speech_pkg SHALL hold the state enum typedef, SAMPLE_W=10, SCORE_W=20, AUDIO_AW=11 and TMPL_IDX_W=3.
REQ-035 Sub-module sad_accum SHALL contain the absolute-difference, saturating-add and clear logic, with inputs en, clr, a and b and output sum.

Verification
REQ-036 Bench SHALL use N_SAMPLES=8, N_TEMPLATES=3; audio all 100; templates 100/90/100 -> done at cycle 31, best_idx=0, best_score=0, match_valid=1.
REQ-037 Bench SHALL use audio 0, templates 1023/500/600 -> best_idx=1, best_score=4000.
REQ-038 Bench SHALL check tie handling: templates 2 and 1 with equal SAD 80, template 0 SAD 200 -> best_idx=1.
REQ-039 Bench SHALL check saturation: N_SAMPLES=1100, audio 0, template 1023 -> best_score=20'hFFFFF, match_valid=0.
REQ-040 Bench SHALL assert reset at cycle 10 of a pass -> busy=0 next cycle, no done pulse, and a new start completes normally.
REQ-041 Bench SHALL assert start on every cycle while busy -> exactly one done pulse per pass.

Source files
------------

// File: rtl/speech_pkg.sv
// speech_pkg: shared widths and FSM state type for the template matcher
package speech_pkg;
  localparam int SAMPLE_W   = 10;
  localparam int SCORE_W    = 20;
  localparam int AUDIO_AW   = 11;
  localparam int TMPL_IDX_W = 3;
  localparam int TMPL_AW    = 13;
  typedef enum logic [2:0] {IDLE, ACCUM, FLUSH, CMP, DONE} state_t;
endpackage

// File: rtl/sad_accum.sv
// sad_accum: saturating sum-of-absolute-differences accumulator with clear
module sad_accum
  import speech_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                clr,
  input  logic [SAMPLE_W-1:0] a,
  input  logic [SAMPLE_W-1:0] b,
  output logic [SCORE_W-1:0]  sum
);
  logic [SAMPLE_W-1:0] diff;
  logic [SCORE_W:0]    total;
  always_comb begin
    diff  = a > b ? a - b : b - a;
    total = {1'b0, sum} + (SCORE_W + 1)'(diff);
  end
  always_ff @(posedge clk) begin
    if (reset || clr) sum <= '0;
    else if (en) sum <= total[SCORE_W] ? '1 : total[SCORE_W-1:0];
  end
endmodule

// File: rtl/template_match_ctrl.sv
// template_match_ctrl: scores audio against stored templates by SAD and picks the best.
// Optional early abort of losing templates with TEMPLATE_MATCH_EARLY_ABORT_EN.
module template_match_ctrl
  import speech_pkg::*;
#(
  parameter int                 N_SAMPLES   = 1000,
  parameter int                 N_TEMPLATES = 4,
  parameter logic [SCORE_W-1:0] THRESHOLD   = 20'd200000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [AUDIO_AW-1:0]   audio_addr,
  input  logic [SAMPLE_W-1:0]   audio_data,
  output logic [TMPL_AW-1:0]    tmpl_addr,
  input  logic [SAMPLE_W-1:0]   tmpl_data,
  output logic                  busy,
  output logic                  done,
  output logic [TMPL_IDX_W-1:0] best_idx,
  output logic [SCORE_W-1:0]    best_score,
  output logic                  match_valid
);
  state_t                state, state_nxt;
  logic [AUDIO_AW-1:0]   s;
  logic [TMPL_IDX_W-1:0] t;
  logic [SCORE_W-1:0]    sum;
  logic                  en, last_s, last_t, win;
  sad_accum u_sad (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .clr  (state == CMP),
    .a    (audio_data),
    .b    (tmpl_data),
    .sum  (sum)
  );
  always_comb begin
    last_s     = s == AUDIO_AW'(N_SAMPLES - 1);
    last_t     = t == TMPL_IDX_W'(N_TEMPLATES - 1);
    win        = t == '0 || sum < best_score;
    busy       = state != IDLE;
    done       = state == DONE;
    audio_addr = state == ACCUM ? s : '0;
    tmpl_addr  = state == ACCUM ? {t, s[AUDIO_AW-2:0]} : '0;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = start ? ACCUM : IDLE;
`ifdef TEMPLATE_MATCH_EARLY_ABORT_EN
      // a template already scoring no better than the best can never win
      ACCUM: state_nxt = (t != '0 && sum >= best_score) ? CMP : last_s ? FLUSH : ACCUM;
`else
      ACCUM: state_nxt = last_s ? FLUSH : ACCUM;
`endif
      FLUSH: state_nxt = CMP;
      CMP:   state_nxt = last_t ? DONE : ACCUM;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      s           <= '0;
      t           <= '0;
      en          <= 1'b0;
      best_idx    <= '0;
      best_score  <= '0;
      match_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      // memory data lags the address by one cycle
      en    <= state == ACCUM;
      s     <= state == ACCUM ? s + 1'b1 : '0;
      if (state == IDLE && start) begin
        best_score  <= '1;
        best_idx    <= '0;
        match_valid <= 1'b0;
      end
      if (state == CMP) begin
        t <= last_t ? '0 : t + 1'b1;
        if (win) begin
          best_score <= sum;
          best_idx   <= t;
        end
        if (last_t) match_valid <= (win ? sum : best_score) < THRESHOLD;
      end
    end
  end
endmodule

// File: tb/tb_template_match_ctrl.sv
// tb_template_match_ctrl: directed and random passes checked against a SAD reference model
module tb_template_match_ctrl;
  localparam int NS = 8;
  localparam int NT = 3;
  localparam int THR = 4000;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, start_s = 1'b0;
  logic [10:0] audio_addr, audio_addr_s;
  logic [12:0] tmpl_addr, tmpl_addr_s;
  logic [9:0]  audio_data, tmpl_data, audio_data_s, tmpl_data_s;
  logic        busy, done, match_valid, busy_s, done_s, match_valid_s;
  logic [2:0]  best_idx, best_idx_s;
  logic [19:0] best_score, best_score_s;
  int compared = 0, mismatched = 0;
  logic [9:0] audio_mem[NS];
  logic [9:0] tmpl_mem[8][NS];

  always #5 clk = ~clk;

  template_match_ctrl #(.N_SAMPLES(NS), .N_TEMPLATES(NT), .THRESHOLD(20'(THR))) dut (
    .clk(clk), .reset(reset), .start(start), .audio_addr(audio_addr), .audio_data(audio_data),
    .tmpl_addr(tmpl_addr), .tmpl_data(tmpl_data), .busy(busy), .done(done),
    .best_idx(best_idx), .best_score(best_score), .match_valid(match_valid));

  template_match_ctrl #(.N_SAMPLES(1100), .N_TEMPLATES(1)) dut_sat (
    .clk(clk), .reset(reset), .start(start_s), .audio_addr(audio_addr_s), .audio_data(audio_data_s),
    .tmpl_addr(tmpl_addr_s), .tmpl_data(tmpl_data_s), .busy(busy_s), .done(done_s),
    .best_idx(best_idx_s), .best_score(best_score_s), .match_valid(match_valid_s));

  always @(posedge clk) begin
    audio_data   <= audio_addr < 11'(NS) ? audio_mem[audio_addr[2:0]] : 10'd777;
    tmpl_data    <= tmpl_addr[9:0] < 10'(NS) ? tmpl_mem[tmpl_addr[12:10]][tmpl_addr[2:0]] : 10'd777;
    audio_data_s <= 10'd0;
    tmpl_data_s  <= 10'd1023;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model(output int idx, output int score);
    int sum;
    idx = 0;
    score = 0;
    for (int k = 0; k < NT; k++) begin
      sum = 0;
      for (int i = 0; i < NS; i++) begin
        sum += (audio_mem[i] > tmpl_mem[k][i]) ? int'(audio_mem[i]) - int'(tmpl_mem[k][i])
                                               : int'(tmpl_mem[k][i]) - int'(audio_mem[i]);
        if (sum > 'hFFFFF) sum = 'hFFFFF;
      end
      if (k == 0 || sum < score) begin
        idx = k;
        score = sum;
      end
    end
  endtask

  task automatic fill(input int a, input int v0, input int v1, input int v2);
    for (int i = 0; i < NS; i++) begin
      audio_mem[i]   = 10'(a);
      tmpl_mem[0][i] = 10'(v0);
      tmpl_mem[1][i] = 10'(v1);
      tmpl_mem[2][i] = 10'(v2);
    end
  endtask

  task automatic run_pass(input string tag, input bit spam);
    int idx, score, lat, ndone;
    logic [19:0] held;
    model(idx, score);
    lat = 0;
    ndone = 0;
    start = 1'b1;
    @(posedge clk); #1;
    if (!spam) start = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      if (c == 2) check({tag, ".addr1"}, 32'(audio_addr), 32'd1);
      if (done) begin
        ndone++;
        if (lat == 0) lat = c;
      end
      if (!busy) begin
        start = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    check({tag, ".latency"}, 32'(lat), 32'(NT * (NS + 2) + 1));
    check({tag, ".ndone"}, 32'(ndone), 32'd1);
    check({tag, ".best_idx"}, 32'(best_idx), 32'(idx));
    check({tag, ".best_score"}, 32'(best_score), 32'(score));
    check({tag, ".match_valid"}, 32'(match_valid), 32'(score < THR));
    held = best_score;
    repeat (3) @(posedge clk);
    #1;
    check({tag, ".hold"}, 32'(best_score), 32'(held));
  endtask

  initial begin
    int nd, lat;
    fill(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", 32'(busy), 0);
    check("rst.done", 32'(done), 0);
    check("rst.best_idx", 32'(best_idx), 0);
    check("rst.best_score", 32'(best_score), 0);
    check("rst.match_valid", 32'(match_valid), 0);
    check("rst.audio_addr", 32'(audio_addr), 0);
    check("rst.tmpl_addr", 32'(tmpl_addr), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    fill(100, 100, 90, 100);
    run_pass("equal", 1'b0);
    check("equal.exp_score", 32'(best_score), 0);
    fill(0, 1023, 500, 600);
    run_pass("spread", 1'b0);
    check("spread.exp_score", 32'(best_score), 4000);
    fill(0, 25, 10, 10);
    run_pass("tie", 1'b0);
    check("tie.exp_idx", 32'(best_idx), 1);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NS; i++) begin
        audio_mem[i] = 10'($urandom_range(0, 1023));
        for (int k = 0; k < NT; k++) tmpl_mem[k][i] = 10'($urandom_range(0, 1023));
      end
      run_pass($sformatf("rand%0d", r), r[0]);
    end

    fill(0, 500, 1000, 5);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst.busy", 32'(busy), 0);
    check("midrst.best_score", 32'(best_score), 0);
    nd = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    check("midrst.no_done", 32'(nd), 0);
    run_pass("after_rst", 1'b0);
    run_pass("spam", 1'b1);

    lat = 0;
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    for (int c = 1; c <= 1200; c++) begin
      if (done_s) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    check("sat.latency", 32'(lat), 32'd1103);
    check("sat.best_score", 32'(best_score_s), 32'hFFFFF);
    check("sat.match_valid", 32'(match_valid_s), 0);
    check("sat.best_idx", 32'(best_idx_s), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
